emulador_teclado: RTL and testbench

Synthesizable 4x4 matrix-keypad emulator: the passive key-switch end of the keypad scan interface. It sits opposite the keypad scanner, watching the scanner's active-low column drive and pulling the matching active-low row line when an emulated key is closed. Key presses are requested through a valid/ready command port. Each press runs a bounce / hold / bounce sequence, so scanner debounce and decode can be exercised in hardware-in-loop and regression benches without a physical keypad.

---
 rtl/emulador_teclado.sv | 177 +++++++++++++++++
 tb/tb_emulador_teclado.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/emulador_teclado.sv
// ---------------------------------------------------------------------------
// emulador_teclado
//
// Passive 4x4 matrix-keypad emulator. It sits on the key-switch side of a
// keypad scan interface: the scanner drives one column low at a time and the
// emulator pulls the matching row low while an emulated key is closed.
// Each accepted press runs bounce / solid hold / bounce, then pulses listo.
//
// Parameters
//   REBOTE_CICLOS   cycles of contact bounce on press and on release (0 = none)
//   MANTENER_CICLOS cycles of solid contact, 1..65535
//
// Ports
//   clk           system clock, all state on the rising edge
//   rst_n         asynchronous active-low reset
//   tecla_valid   press request
//   tecla_ready   emulator can accept a request (state IDLE)
//   tecla_codigo  key index = fila*4 + columna
//   columnas      scanner column drive, active-low, columna c on columnas[3-c]
//   filas         row sense back to scanner, active-low, fila f on filas[3-f]
//   ocupado       press sequence in progress
//   listo         one-cycle pulse when the sequence completes
//   estado_dbg    current FSM state, for checkers and debug
//
// Handshake: a request transfers on a rising edge where tecla_valid and
// tecla_ready are both high. tecla_codigo is only sampled on that edge.
// A request presented while busy is not stored; the requester must hold
// tecla_valid until it sees tecla_ready.
// ---------------------------------------------------------------------------
module emulador_teclado #(
  parameter int REBOTE_CICLOS   = 8,
  parameter int MANTENER_CICLOS = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tecla_valid,
  output logic       tecla_ready,
  input  logic [3:0] tecla_codigo,
  input  logic [3:0] columnas,
  output logic [3:0] filas,
  output logic       ocupado,
  output logic       listo,
  output logic [2:0] estado_dbg
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    REBOTE_ON  = 3'd1,
    PRESIONADO = 3'd2,
    REBOTE_OFF = 3'd3,
    FIN        = 3'd4
  } estado_t;

  // Counter reload values: a state lasting N cycles is entered with N-1.
  localparam logic [15:0] CARGA_REBOTE   =
    16'((REBOTE_CICLOS > 0) ? (REBOTE_CICLOS - 1) : 0);
  localparam logic [15:0] CARGA_MANTENER =
    16'((MANTENER_CICLOS > 0) ? (MANTENER_CICLOS - 1) : 0);
  localparam bit SIN_REBOTE = (REBOTE_CICLOS == 0);

  estado_t     estado_q, estado_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  fila_q, fila_d;
  logic [1:0]  col_q, col_d;
  logic        contacto_q, contacto_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic        acepta;

  assign acepta = tecla_valid && tecla_ready;

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1. It free-runs from reset so that the
  // bounce pattern of a press depends only on the cycle it was accepted in.
  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q   <= IDLE;
      cnt_q      <= 16'd0;
      fila_q     <= 2'd0;
      col_q      <= 2'd0;
      contacto_q <= 1'b0;
      lfsr_q     <= 8'hA5;
    end else begin
      estado_q   <= estado_d;
      cnt_q      <= cnt_d;
      fila_q     <= fila_d;
      col_q      <= col_d;
      contacto_q <= contacto_d;
      lfsr_q     <= lfsr_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    cnt_d    = (cnt_q == 16'd0) ? 16'd0 : (cnt_q - 16'd1);
    fila_d   = fila_q;
    col_d    = col_q;

    case (estado_q)
      IDLE: begin
        if (acepta) begin
          fila_d = tecla_codigo[3:2];
          col_d  = tecla_codigo[1:0];
          if (SIN_REBOTE) begin
            estado_d = PRESIONADO;
            cnt_d    = CARGA_MANTENER;
          end else begin
            estado_d = REBOTE_ON;
            cnt_d    = CARGA_REBOTE;
          end
        end
      end
      REBOTE_ON: begin
        if (cnt_q == 16'd0) begin
          estado_d = PRESIONADO;
          cnt_d    = CARGA_MANTENER;
        end
      end
      PRESIONADO: begin
        if (cnt_q == 16'd0) begin
          if (SIN_REBOTE) begin
            estado_d = FIN;
            cnt_d    = 16'd0;
          end else begin
            estado_d = REBOTE_OFF;
            cnt_d    = CARGA_REBOTE;
          end
        end
      end
      REBOTE_OFF: begin
        if (cnt_q == 16'd0) begin
          estado_d = FIN;
          cnt_d    = 16'd0;
        end
      end
      FIN: begin
        estado_d = IDLE;
        cnt_d    = 16'd0;
      end
      default: begin
        estado_d = IDLE;
        cnt_d    = 16'd0;
      end
    endcase

    // Contact is registered from the state being entered, so the first
    // visible contact appears in the cycle right after the accept edge.
    case (estado_d)
      PRESIONADO:            contacto_d = 1'b1;
      REBOTE_ON, REBOTE_OFF: contacto_d = lfsr_q[0];
      default:               contacto_d = 1'b0;
    endcase
  end

  // Passive switch: the row follows the latched column combinationally.
  // Other driven columns are ignored (no ghosting).
  always_comb begin
    filas = 4'b1111;
    if (contacto_q && !columnas[2'd3 - col_q]) begin
      filas[2'd3 - fila_q] = 1'b0;
    end
  end

  assign tecla_ready = (estado_q == IDLE);
  assign ocupado     = (estado_q != IDLE);
  assign listo       = (estado_q == FIN);
  assign estado_dbg  = estado_q;

  // Hold length must fit the 16-bit counter and cannot be zero.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (MANTENER_CICLOS >= 1 && MANTENER_CICLOS <= 65535)
        else $error("emulador_teclado: MANTENER_CICLOS out of range 1..65535");
    end
  end

endmodule

// File: tb/tb_emulador_teclado.sv
// ---------------------------------------------------------------------------
// tb_emulador_teclado
//
// Two emulator instances share clock and reset:
//   u_a : REBOTE_CICLOS=0, MANTENER_CICLOS=4  (no bounce)
//   u_b : REBOTE_CICLOS=8, MANTENER_CICLOS=16 (bounce)
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// at the same point, i.e. each "window" is the cycle following an edge.
// ---------------------------------------------------------------------------
module tb_emulador_teclado;

  logic       clk;
  logic       rst_n;

  logic       valid_a, ready_a, ocupado_a, listo_a;
  logic [3:0] codigo_a, columnas_a, filas_a;
  logic [2:0] est_a;

  logic       valid_b, ready_b, ocupado_b, listo_b;
  logic [3:0] codigo_b, columnas_b, filas_b;
  logic [2:0] est_b;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference LFSR seeded A5 at reset, advancing every edge. ref_prev_bit is
  // the bit0 the LFSR held just before the most recent edge.
  logic [7:0] ref_lfsr;
  logic       ref_prev_bit;

  emulador_teclado #(.REBOTE_CICLOS(0), .MANTENER_CICLOS(4)) u_a (
    .clk(clk), .rst_n(rst_n),
    .tecla_valid(valid_a), .tecla_ready(ready_a), .tecla_codigo(codigo_a),
    .columnas(columnas_a), .filas(filas_a),
    .ocupado(ocupado_a), .listo(listo_a), .estado_dbg(est_a)
  );

  emulador_teclado #(.REBOTE_CICLOS(8), .MANTENER_CICLOS(16)) u_b (
    .clk(clk), .rst_n(rst_n),
    .tecla_valid(valid_b), .tecla_ready(ready_b), .tecla_codigo(codigo_b),
    .columnas(columnas_b), .filas(filas_b),
    .ocupado(ocupado_b), .listo(listo_b), .estado_dbg(est_b)
  );

  // Clock / reset-independent reference
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_lfsr     <= 8'hA5;
      ref_prev_bit <= 1'b0;
    end else begin
      ref_prev_bit <= ref_lfsr[0];
      ref_lfsr     <= {ref_lfsr[6:0],
                       ref_lfsr[7] ^ ref_lfsr[5] ^ ref_lfsr[4] ^ ref_lfsr[3]};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Checking and driver tasks
  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Checks a full u_b press (8 bounce, 16 hold, 8 bounce, FIN) starting in
  // window first_w after the accept edge; ends in the FIN window.
  task automatic check_seq_b(input logic [3:0] row_mask, input int first_w,
                             input string tag);
    logic c;
    for (int w = first_w; w <= 33; w++) begin
      if (w >= 9 && w <= 24) c = 1'b1;
      else if (w == 33)      c = 1'b0;
      else                   c = ref_prev_bit;
      check({tag, "_filas"}, filas_b, c ? row_mask : 4'b1111);
      check({tag, "_listo"}, listo_b, (w == 33));
      check({tag, "_ocupado"}, ocupado_b, 1'b1);
      if (w < 33) tick();
    end
  endtask

  logic [3:0] sel_pat [5];
  logic [3:0] sel_exp [5];
  int lc [3];
  int npulse;
  int l1, l2;

  initial begin
    sel_pat = '{4'b0111, 4'b1011, 4'b1101, 4'b1110, 4'b0000};
    sel_exp = '{4'b1111, 4'b1111, 4'b1011, 4'b1111, 4'b1011};
    lc = '{0, 0, 0};

    rst_n = 1'b0;
    valid_a = 1'b0; codigo_a = 4'h0; columnas_a = 4'b1111;
    valid_b = 1'b0; codigo_b = 4'h0; columnas_b = 4'b1111;

    // Reset state
    #2;
    check("rst_filas_a", filas_a, 4'b1111);
    check("rst_ready_a", ready_a, 1'b1);
    check("rst_ocupado_a", ocupado_a, 1'b0);
    check("rst_listo_a", listo_a, 1'b0);
    check("rst_estado_a", est_a, 3'd0);
    check("rst_filas_b", filas_b, 4'b1111);
    check("rst_ready_b", ready_b, 1'b1);
    check("rst_listo_b", listo_b, 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Basic press on u_a: key 0, column 0 driven throughout
    columnas_a = 4'b0111; codigo_a = 4'h0; valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    for (int w = 1; w <= 4; w++) begin
      check("basic_hold_filas", filas_a, 4'b0111);
      check("basic_hold_listo", listo_a, 1'b0);
      check("basic_hold_ready", ready_a, 1'b0);
      tick();
    end
    check("basic_listo", listo_a, 1'b1);
    check("basic_fin_filas", filas_a, 4'b1111);
    check("basic_fin_ready", ready_a, 1'b0);
    tick();
    check("basic_idle_listo", listo_a, 1'b0);
    check("basic_idle_ready", ready_a, 1'b1);
    check("basic_idle_ocupado", ocupado_a, 1'b0);
    check("basic_idle_filas", filas_a, 4'b1111);

    // Column selectivity on u_a: key 6 = fila 1, columna 2
    codigo_a = 4'h6; valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    for (int w = 1; w <= 4; w++) begin
      for (int p = 0; p < 5; p++) begin
        columnas_a = sel_pat[p];
        #1;
        check("colsel_filas", filas_a, sel_exp[p]);
      end
      tick();
    end
    check("colsel_listo", listo_a, 1'b1);
    columnas_a = 4'b1101;
    #1;
    check("colsel_fin_filas", filas_a, 4'b1111);
    tick();

    // Bounce on u_b: key F = fila 3, columna 3
    columnas_b = 4'b1110; codigo_b = 4'hF; valid_b = 1'b1;
    tick();
    valid_b = 1'b0;
    check_seq_b(4'b1110, 1, "bounce");
    tick();
    check("bounce_idle_ready", ready_b, 1'b1);
    check("bounce_idle_filas", filas_b, 4'b1111);

    // Busy rejection: key 0 pressed, key 3 held valid during the sequence
    columnas_b = 4'b0111; codigo_b = 4'h0; valid_b = 1'b1;
    tick();
    codigo_b = 4'h3;
    check("busy_ready", ready_b, 1'b0);
    check_seq_b(4'b0111, 1, "busy_orig");
    l1 = cyc;
    tick();
    check("busy_idle_ready", ready_b, 1'b1);
    check("busy_idle_ocupado", ocupado_b, 1'b0);
    columnas_b = 4'b1110;
    tick();
    valid_b = 1'b0;
    check_seq_b(4'b0111, 1, "busy_second");
    l2 = cyc;
    check("busy_listo_spacing", l2 - l1, 34);
    tick();

    // Reset mid-hold on u_b
    columnas_b = 4'b1110; codigo_b = 4'hF; valid_b = 1'b1;
    tick();
    valid_b = 1'b0;
    repeat (12) tick();
    check("hold_pre_reset_filas", filas_b, 4'b1110);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_filas", filas_b, 4'b1111);
    check("mid_rst_ready", ready_b, 1'b1);
    check("mid_rst_ocupado", ocupado_b, 1'b0);
    tick();
    rst_n = 1'b1;
    codigo_b = 4'hF; valid_b = 1'b1;
    check("post_rst_ready", ready_b, 1'b1);
    tick();
    valid_b = 1'b0;
    // A5 -> 4A -> 95: bit0 sequence 1,0,1 for the first three bounce windows
    check("restart_w1_filas", filas_b, 4'b1110);
    tick();
    check("restart_w2_filas", filas_b, 4'b1111);
    tick();
    check("restart_w3_filas", filas_b, 4'b1110);
    tick();
    check_seq_b(4'b1110, 4, "restart");
    tick();

    // Back-to-back on u_a: key 5 held valid, listo every 6 cycles
    columnas_a = 4'b1011; codigo_a = 4'h5; valid_a = 1'b1;
    npulse = 0;
    for (int i = 0; i < 40 && npulse < 3; i++) begin
      tick();
      if (listo_a) begin
        lc[npulse] = cyc;
        npulse++;
      end else if (ocupado_a && npulse == 0) begin
        check("b2b_hold_filas", filas_a, 4'b1011);
      end
    end
    valid_a = 1'b0;
    check("b2b_pulse_count", npulse, 3);
    check("b2b_spacing_1", lc[1] - lc[0], 6);
    check("b2b_spacing_2", lc[2] - lc[1], 6);
    repeat (8) tick();
    check("b2b_end_ready", ready_a, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
